// File: rtl/regfile_pkg.sv
// Shared sizing for the register file and its write-select decoder.
package regfile_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage : regfile_pkg

// File: rtl/decoder.sv
// 5-to-32 binary to one-hot decoder used as the register file write select.
// Ports:
//   addr   - binary register address
//   onehot - exactly one bit set, at position addr
module decoder
  import regfile_pkg::*;
(
  input  logic [ADDR_W-1:0]   addr,
  output logic [NUM_REGS-1:0] onehot
);

  always_comb begin
    onehot       = '0;
    onehot[addr] = 1'b1;
  end

endmodule : decoder

// File: rtl/register32.sv
// Single storage word: DFF with load enable and asynchronous active-high clear.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous active-high clear to 0
//   en    - load d on the next rising edge
//   d     - data in
//   q     - stored data
module register32
  import regfile_pkg::*;
#(
  parameter int unsigned W = DATA_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : register32

// File: rtl/regfile.sv
// Two-read, one-write register file with hardwired-zero r0 and same-cycle
// write-to-read bypass.
// Ports:
//   clock            - rising-edge clock
//   reset            - asynchronous active-high clear of all registers
//   ctrl_writeEnable - qualifies a write this cycle
//   ctrl_writeReg    - write address
//   data_writeReg    - write data
//   ctrl_readRegA/B  - read addresses
//   data_readRegA/B  - combinational read data
module regfile #(
  parameter int unsigned NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int unsigned DATA_W   = regfile_pkg::DATA_W
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          ctrl_writeEnable,
  input  logic [regfile_pkg::ADDR_W-1:0] ctrl_writeReg,
  input  logic [DATA_W-1:0]             data_writeReg,
  input  logic [regfile_pkg::ADDR_W-1:0] ctrl_readRegA,
  input  logic [regfile_pkg::ADDR_W-1:0] ctrl_readRegB,
  output logic [DATA_W-1:0]             data_readRegA,
  output logic [DATA_W-1:0]             data_readRegB
);

  localparam int unsigned ADDR_W = regfile_pkg::ADDR_W;

  logic [NUM_REGS-1:0] dec_onehot;
  logic [NUM_REGS-1:0] wr_sel;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic                unused_sel0;
  logic                hit_a;
  logic                hit_b;

  // Write select: decoded address gated by the write enable.
  decoder u_dec (
    .addr   (ctrl_writeReg),
    .onehot (dec_onehot)
  );

  assign wr_sel = dec_onehot & {NUM_REGS{ctrl_writeEnable}};

  // r0 has no storage, so its select line goes nowhere.
  assign unused_sel0 = wr_sel[0];
  assign regs[0]     = '0;

  // Storage for r1..r31.
  for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
    register32 #(.W(DATA_W)) u_reg (
      .clock (clock),
      .reset (reset),
      .en    (wr_sel[i]),
      .d     (data_writeReg),
      .q     (regs[i])
    );
  end

  // Bypass only for a live, non-zero write address matching the read port.
  assign hit_a = !reset && ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegA)
               && (ctrl_readRegA != ADDR_W'(0));
  assign hit_b = !reset && ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegB)
               && (ctrl_readRegB != ADDR_W'(0));

  // Read paths: 32:1 storage mux followed by the bypass mux.
  always_comb begin
    data_readRegA = regs[ctrl_readRegA];
    data_readRegB = regs[ctrl_readRegB];
    if (hit_a) data_readRegA = data_writeReg;
    if (hit_b) data_readRegB = data_writeReg;
  end

endmodule : regfile

// File: tb/tb_regfile.sv
// Randomized and directed self-checking bench for regfile against an
// array-based behavioural model.
module tb_regfile;

  logic        clock;
  logic        reset;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;

  int          checks;
  int          errors;
  logic [31:0] model [32];

  regfile dut (
    .clock            (clock),
    .reset            (reset),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endfunction

  // Architectural view of a read given the inputs currently applied.
  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (reset || a == 5'd0) return 32'h0;
    if (ctrl_writeEnable && ctrl_writeReg == a) return data_writeReg;
    return model[int'(a)];
  endfunction

  // One cycle: apply inputs after a falling edge, check reads, take the edge.
  task automatic cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb, input string tag);
    ctrl_writeEnable = we;
    ctrl_writeReg    = wa;
    data_writeReg    = wd;
    ctrl_readRegA    = ra;
    ctrl_readRegB    = rb;
    #1;
    check({tag, "_a"}, data_readRegA, exp_read(ra));
    check({tag, "_b"}, data_readRegB, exp_read(rb));
    @(posedge clock);
    if (reset) model_clear();
    else if (we && wa != 5'd0) model[int'(wa)] = wd;
    @(negedge clock);
  endtask

  task automatic sweep_pairs(input string tag);
    for (int i = 0; i < 32; i++) cycle(1'b0, 5'(i), 32'h0, 5'(i), 5'(31 - i), tag);
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    reset            = 1'b1;
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = '0;
    data_writeReg    = '0;
    ctrl_readRegA    = '0;
    ctrl_readRegB    = '0;
    model_clear();

    // Reset state, including upper addresses.
    repeat (2) @(negedge clock);
    for (int i = 0; i < 32; i += 5) begin
      ctrl_readRegA = 5'(i);
      ctrl_readRegB = 5'(31 - i);
      #1;
      check("rst_init_a", data_readRegA, 32'h0);
      check("rst_init_b", data_readRegB, 32'h0);
    end
    @(negedge clock);
    reset = 1'b0;

    // Write r5 then assert reset mid-cycle: clears with no clock edge.
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd6, "wr5");
    cycle(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, "rd5");
    ctrl_readRegA = 5'd5;
    ctrl_readRegB = 5'd5;
    #1;
    reset = 1'b1;
    #1;
    check("rst_async_a", data_readRegA, 32'h0);
    check("rst_async_b", data_readRegB, 32'h0);
    model_clear();
    for (int i = 1; i < 32; i++) begin
      ctrl_readRegA = 5'(i);
      ctrl_readRegB = 5'(32 - i);
      #1;
      check("rst_sweep_a", data_readRegA, 32'h0);
      check("rst_sweep_b", data_readRegB, 32'h0);
    end

    // Bypass suppressed under reset; coinciding write is lost.
    @(negedge clock);
    cycle(1'b1, 5'd5, 32'h12341234, 5'd5, 5'd5, "rst_byp");
    reset = 1'b0;
    cycle(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, "rst_win");

    // First edge after reset writes normally.
    cycle(1'b1, 5'd12, 32'hCAFEF00D, 5'd1, 5'd2, "post_rst_wr");
    cycle(1'b0, 5'd12, 32'h0, 5'd12, 5'd12, "post_rst_rd");

    // Basic write/read, both ports same address.
    cycle(1'b1, 5'd7, 32'h12345678, 5'd3, 5'd4, "wr7");
    cycle(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, "rd7");

    // Write to r0 discarded, in the write cycle and after.
    cycle(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, "wr0");
    cycle(1'b0, 5'd0, 32'h0, 5'd0, 5'd7, "rd0");
    sweep_pairs("r0_side");

    // Bypass on A only; B sees storage.
    cycle(1'b1, 5'd9, 32'hAAAA0000, 5'd0, 5'd0, "pre9");
    cycle(1'b1, 5'd9, 32'h5555FFFF, 5'd9, 5'd10, "byp9");
    cycle(1'b0, 5'd0, 32'h0, 5'd9, 5'd10, "rd9");

    // Write-disable leaves the register alone.
    cycle(1'b1, 5'd3, 32'h1, 5'd0, 5'd0, "pre3");
    cycle(1'b0, 5'd3, 32'h2, 5'd3, 5'd3, "we0");
    cycle(1'b0, 5'd0, 32'h0, 5'd3, 5'd3, "rd3");

    // Full sweep r[i] = i * 0x01010101.
    for (int i = 1; i < 32; i++) cycle(1'b1, 5'(i), 32'(i) * 32'h01010101, 5'(i), 5'(31 - i), "fill");
    sweep_pairs("sweep");
    for (int i = 0; i < 32; i++) begin
      ctrl_readRegA = 5'(i);
      #1;
      check("sweep_abs", data_readRegA, 32'(i) * 32'h01010101);
    end
    @(negedge clock);

    // Random traffic with occasional asynchronous reset pulses.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        ctrl_readRegA = 5'($urandom_range(0, 31));
        ctrl_readRegB = 5'($urandom_range(0, 31));
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        check("rnd_rst_a", data_readRegA, 32'h0);
        check("rnd_rst_b", data_readRegB, 32'h0);
        @(negedge clock);
        reset = 1'b0;
      end else begin
        logic [4:0] wa;
        logic [4:0] ra;
        logic [4:0] rb;
        wa = 5'($urandom_range(0, 31));
        ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
        rb = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
        cycle(1'($urandom_range(0, 1)), wa, $urandom, ra, rb, "rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_regfile
